// File: rtl/mux4_rr_arb_ctrl_pkg.sv
// mux4_arb_pkg: shared state type, requester count and one-hot helper for mux4_rr_arb_ctrl
//   NREQ    number of requesters sharing the 4:1 mux
//   state_t arbiter FSM states
//   onehot2 2-bit index to 4-bit one-hot grant
package mux4_arb_pkg;
    localparam int NREQ = 4;
    typedef enum logic {ST_IDLE, ST_GRANT} state_t;
    function automatic logic [NREQ-1:0] onehot2(input logic [1:0] s);
        return NREQ'(1) << s;
    endfunction
endpackage

// File: rtl/mux4_rr_arb_ctrl_if.sv
// mux4_rr_arb_ctrl_if: requester/consumer side bundle of the shared-mux arbiter
//   req, last   per-requester beat pending / last-beat flag
//   out_ready   downstream accepts a beat
//   sel, gnt    registered mux select and one-hot grant
//   out_valid   mux output carries a valid beat
//   ack         per-requester beat accepted
//   busy, tmo   grant held / watchdog revocation pulse
//   master drives requests, slave is the arbiter
interface mux4_rr_arb_ctrl_if;
    import mux4_arb_pkg::*;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] last;
    logic            out_ready;
    logic [1:0]      sel;
    logic [NREQ-1:0] gnt;
    logic            out_valid;
    logic [NREQ-1:0] ack;
    logic            busy;
    logic            tmo;
    modport master (output req, last, out_ready, input sel, gnt, out_valid, ack, busy, tmo);
    modport slave  (input req, last, out_ready, output sel, gnt, out_valid, ack, busy, tmo);
endinterface

// File: rtl/mux4_rr_arb_ctrl_rr_pick4.sv
// rr_pick4: combinational round-robin pick among four requests
//   req   request vector
//   ptr   highest-priority index; search runs upward and wraps 3->0
//   found any request set
//   win   index of the first set request at or after ptr
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic            found,
    output logic [1:0]      win
);
    // Scanning offsets from far to near lets the nearest set bit overwrite the rest;
    // the 2-bit sum wraps naturally.
    always_comb begin
        found = |req;
        win = ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[ptr + 2'(k)]) win = ptr + 2'(k);
    end
endmodule

// File: rtl/mux4_rr_arb_ctrl.sv
// mux4_rr_arb_ctrl: round-robin arbiter sequencing four requesters onto one shared 4:1 mux
//   clk, rst  clock and synchronous active-high reset
//   bus       mux4_rr_arb_ctrl_if.slave: req/last/out_ready in; sel/gnt/out_valid/ack/busy/tmo out
//   TMO_CYC   stalled cycles before the watchdog revokes a grant (1..2^TMO_W-1)
//   TMO_W     watchdog counter width
//   ARB_BACK2BACK_EN  when defined, a last-beat release hands over to the next owner with no idle bubble
module mux4_rr_arb_ctrl
    import mux4_arb_pkg::*;
#(
    parameter int TMO_CYC = 15,
    parameter int TMO_W   = 4
)
(
    input logic               clk,
    input logic               rst,
    mux4_rr_arb_ctrl_if.slave bus
);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    state_t          state, state_n;
    logic [1:0]      sel, sel_n, ptr, ptr_n, idle_win;
    logic [NREQ-1:0] gnt, gnt_n;
    logic [TMO_W-1:0] cnt, cnt_n;
    logic            idle_found, owner_req, busy, out_valid, xfer, rel, tmo;
    rr_pick4 u_idle_pick (.req(bus.req), .ptr(ptr), .found(idle_found), .win(idle_win));
`ifdef ARB_BACK2BACK_EN
    logic            b2b_found;
    logic [1:0]      b2b_win;
    // The departing owner is masked so a lone requester still sees a bubble.
    rr_pick4 u_b2b_pick (.req(bus.req & ~gnt), .ptr(sel + 2'd1), .found(b2b_found), .win(b2b_win));
`endif
    assign owner_req = bus.req[sel];
    assign busy      = state == ST_GRANT;
    assign out_valid = busy & owner_req;
    assign xfer      = out_valid & bus.out_ready;
    assign rel       = xfer & bus.last[sel];
    // Fires in the TMO_CYC-th consecutive stalled cycle; owner_req is low so no ack coincides.
    assign tmo       = busy & ~owner_req & (cnt == TMO_LAST);
    assign bus.sel       = sel;
    assign bus.gnt       = gnt;
    assign bus.out_valid = out_valid;
    assign bus.ack       = gnt & {NREQ{xfer}};
    assign bus.busy      = busy;
    assign bus.tmo       = tmo;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sel   <= '0;
            gnt   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            gnt   <= gnt_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        sel_n   = sel;
        gnt_n   = gnt;
        ptr_n   = ptr;
        cnt_n   = '0;
        if (state == ST_IDLE) begin
            if (idle_found) begin
                state_n = ST_GRANT;
                sel_n   = idle_win;
                gnt_n   = onehot2(idle_win);
            end
        end else if (rel) begin
            ptr_n = sel + 2'd1;
`ifdef ARB_BACK2BACK_EN
            if (b2b_found) begin
                sel_n = b2b_win;
                gnt_n = onehot2(b2b_win);
            end else begin
                state_n = ST_IDLE;
                gnt_n   = '0;
            end
`else
            state_n = ST_IDLE;
            gnt_n   = '0;
`endif
        end else if (tmo) begin
            ptr_n   = sel + 2'd1;
            state_n = ST_IDLE;
            gnt_n   = '0;
        end else begin
            cnt_n = owner_req ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mux4_rr_arb_ctrl.sv
// tb_mux4_rr_arb_ctrl: self-checking bench for mux4_rr_arb_ctrl (vector table, directed corners, random vs model)
module tb_mux4_rr_arb_ctrl;
    import mux4_arb_pkg::*;
    localparam int TMO_CYC = 15;
`ifdef ARB_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    mux4_rr_arb_ctrl_if ifc();
    mux4_rr_arb_ctrl #(.TMO_CYC(TMO_CYC), .TMO_W(4)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));
    always #5 clk = ~clk;

    // Reference model: owner index (-1 = nobody), priority pointer, stall run length, last select
    int m_owner, m_ptr, m_stall, m_sel;

    typedef struct packed {
        logic       r;
        logic [3:0] req;
        logic [3:0] last;
        logic       rdy;
        logic       chk;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic [3:0] ack;
        logic       busy;
        logic       tmo;
    } vec_t;
    vec_t tbl[8];

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic apply(input logic r, input logic [3:0] q, input logic [3:0] l, input logic y);
        @(negedge clk);
        rst = r;
        ifc.req = q;
        ifc.last = l;
        ifc.out_ready = y;
        #1;
    endtask

    task automatic model_step();
        int w;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_stall = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            w = pick(ifc.req, m_ptr);
            if (w >= 0) begin m_owner = w; m_sel = w; end
        end else if (ifc.req[m_owner] && ifc.out_ready && ifc.last[m_owner]) begin
            m_ptr = (m_owner + 1) % 4;
            m_stall = 0;
            if (B2B) begin
                w = pick(ifc.req & ~(4'b0001 << m_owner), m_ptr);
                m_owner = w;
                if (w >= 0) m_sel = w;
            end else m_owner = -1;
        end else if (!ifc.req[m_owner]) begin
            m_stall++;
            if (m_stall == TMO_CYC) begin
                m_ptr = (m_owner + 1) % 4;
                m_owner = -1;
                m_stall = 0;
            end
        end else m_stall = 0;
    endtask

    task automatic check_model(input string tag);
        logic [3:0] eg;
        logic ev, et;
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        ev = (m_owner >= 0) ? ifc.req[m_owner] : 1'b0;
        et = (m_owner >= 0) ? (!ifc.req[m_owner] && (m_stall + 1 == TMO_CYC)) : 1'b0;
        cmp({tag, "_gnt"}, ifc.gnt, eg);
        cmp({tag, "_sel"}, 4'(ifc.sel), 4'(m_sel));
        cmp({tag, "_valid"}, 4'(ifc.out_valid), 4'(ev));
        cmp({tag, "_ack"}, ifc.ack, (ev && ifc.out_ready) ? eg : 4'b0);
        cmp({tag, "_busy"}, 4'(ifc.busy), 4'(m_owner >= 0));
        cmp({tag, "_tmo"}, 4'(ifc.tmo), 4'(et));
    endtask

    task automatic cycle(input logic r, input logic [3:0] q, input logic [3:0] l, input logic y, input string tag);
        apply(r, q, l, y);
        check_model(tag);
        model_step();
    endtask

    initial begin
        int order[5];
        int n;
        logic [3:0] prev, q;
        ifc.req = '0; ifc.last = '0; ifc.out_ready = 1'b0;
        // r, req, last, rdy, chk, gnt, sel, valid, ack, busy, tmo
        tbl[0] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'b1010, 4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 4'b1010, 4'b0000, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 4'b1010, 4'b0000, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 4'b1010, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 4'b1010, 4'b0000, 1'b0, 1'b1, B2B ? 4'b1000 : 4'b0000, B2B ? 2'd3 : 2'd1,
                   B2B, 4'b0000, B2B, 1'b0};
        tbl[7] = '{1'b0, 4'b1010, 4'b0000, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            apply(tbl[i].r, tbl[i].req, tbl[i].last, tbl[i].rdy);
            if (tbl[i].chk) begin
                cmp($sformatf("vec%0d_gnt", i), ifc.gnt, tbl[i].gnt);
                cmp($sformatf("vec%0d_sel", i), 4'(ifc.sel), 4'(tbl[i].sel));
                cmp($sformatf("vec%0d_valid", i), 4'(ifc.out_valid), 4'(tbl[i].valid));
                cmp($sformatf("vec%0d_ack", i), ifc.ack, tbl[i].ack);
                cmp($sformatf("vec%0d_busy", i), 4'(ifc.busy), 4'(tbl[i].busy));
                cmp($sformatf("vec%0d_tmo", i), 4'(ifc.tmo), 4'(tbl[i].tmo));
            end
            model_step();
        end
        // Fairness: everyone requesting, single-beat grants
        cycle(1'b1, 4'h0, 4'h0, 1'b0, "fair_rst");
        prev = 4'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            apply(1'b0, 4'hf, 4'hf, 1'b1);
            check_model("fair");
            if (ifc.busy && ifc.gnt != prev && n < 5) begin
                order[n] = int'(ifc.sel);
                n++;
            end
            prev = ifc.gnt;
            model_step();
        end
        cmp("fair_count", 4'(n), 4'd5);
        for (int k = 0; k < 5; k++) cmp($sformatf("fair_order%0d", k), 4'(order[k]), 4'(k % 4));
        // Backpressure on owner 2 with last held
        cycle(1'b1, 4'h0, 4'h0, 1'b0, "bp_rst");
        cycle(1'b0, 4'b0100, 4'b0100, 1'b0, "bp_arb");
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 4'b0100, 4'b0100, 1'b0);
            check_model("bp");
            cmp("bp_gnt_hold", ifc.gnt, 4'b0100);
            cmp("bp_ack_zero", ifc.ack, 4'b0000);
            model_step();
        end
        apply(1'b0, 4'b0100, 4'b0100, 1'b1);
        check_model("bp_go");
        cmp("bp_ack_go", ifc.ack, 4'b0100);
        model_step();
        apply(1'b0, 4'b0100, 4'b0000, 1'b1);
        check_model("bp_rel");
        cmp("bp_released", 4'(ifc.busy), 4'd0);
        model_step();
        // Watchdog: owner 0 stalls while requester 1 waits
        cycle(1'b1, 4'h0, 4'h0, 1'b0, "wd_rst");
        cycle(1'b0, 4'b0001, 4'b0000, 1'b1, "wd_arb");
        for (int i = 1; i <= 15; i++) begin
            apply(1'b0, 4'b0010, 4'b0000, 1'b1);
            check_model("wd");
            cmp($sformatf("wd_tmo_c%0d", i), 4'(ifc.tmo), 4'(i == 15));
            model_step();
        end
        apply(1'b0, 4'b0010, 4'b0000, 1'b1);
        check_model("wd_off");
        cmp("wd_gnt_off", ifc.gnt, 4'b0000);
        model_step();
        apply(1'b0, 4'b0010, 4'b0000, 1'b1);
        check_model("wd_next");
        cmp("wd_next_owner", ifc.gnt, 4'b0010);
        model_step();
        // Reset in the middle of owner 3's transfer
        cycle(1'b1, 4'h0, 4'h0, 1'b0, "mr_rst");
        cycle(1'b0, 4'b1000, 4'b0000, 1'b1, "mr_arb");
        cycle(1'b0, 4'b1000, 4'b0000, 1'b1, "mr_beat1");
        cycle(1'b1, 4'b1000, 4'b0000, 1'b1, "mr_beat2");
        apply(1'b0, 4'b1001, 4'b0000, 1'b1);
        check_model("mr_after");
        cmp("mr_gnt", ifc.gnt, 4'b0000);
        cmp("mr_sel", 4'(ifc.sel), 4'd0);
        model_step();
        apply(1'b0, 4'b1001, 4'b0000, 1'b1);
        check_model("mr_regrant");
        cmp("mr_owner0", ifc.gnt, 4'b0001);
        model_step();
        // Random traffic with periodic quiet windows to exercise the watchdog
        for (int i = 0; i < 3000; i++) begin
            q = 4'($urandom);
            if ((i % 200) >= 165) q = 4'b0000;
            else if ($urandom_range(0, 3) == 0) q = q & ~ifc.gnt;
            cycle($urandom_range(0, 99) == 0, q, 4'($urandom), $urandom_range(0, 3) != 0, "rnd");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arb_ctrl.md
Name: mux4_rr_arb_ctrl

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 N-bit mux datapath between four requesters.
- Produces the 2-bit mux select plus one-hot grants, and holds the grant for multi-beat transfers until the owner signals its last beat.
- Qualifies the mux output with a valid/ready handshake to the downstream consumer, and revokes a stalled grant via a watchdog counter.
- Sits between requester front-ends and the shared mux select input.

Parameters:
- TMO_CYC, 15, consecutive idle cycles (owner req low while granted) before the grant is revoked; legal range 1..2^TMO_W-1.
- TMO_W, 4, width of the watchdog counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-requester request; bit i = requester i has a beat pending.
- last  input  4  per-requester last-beat flag; sampled only for the current owner.
- out_ready  input  1  downstream accepts a beat this cycle.
- sel  output  2  mux select; drives the shared 4:1 mux s1/s0 (sel[1]=s1).
- gnt  output  4  one-hot grant; all zero when idle.
- out_valid  output  1  mux output holds a valid beat this cycle.
- ack  output  4  per-requester beat accepted: gnt & {4{out_valid & out_ready}}.
- busy  output  1  a grant is held (state GRANT).
- tmo  output  1  single-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE, gnt=0, sel=0, ptr=0 (requester 0 has highest priority), tmo counter=0, tmo=0. Combinational outputs follow: out_valid=0, ack=0, busy=0. Reset mid-transfer aborts the transfer with no further ack.
- State IDLE:
  - If req!=0, search from ptr upward, wrapping 3->0; the first set bit w wins.
  - At the next edge: state=GRANT, sel=w, gnt=onehot(w).
  - Latency is 1 cycle from req to gnt.
- State GRANT:
  - out_valid = req[sel] (combinational).
  - A beat transfers when out_valid & out_ready.
- Release on a transfer with last[sel]=1:
  - ptr = sel+1 (mod 4).
  - Without the optional feature: state=IDLE, gnt=0. This leaves one dead cycle between owners.
- Owner stall (req[sel]=0 while in GRANT):
  - The tmo counter increments each cycle and clears on any cycle with req[sel]=1.
  - When the counter reaches TMO_CYC: tmo=1 for one cycle, ptr=sel+1, state=IDLE, counter=0. No ack is issued in that cycle.
- Non-owner req bits are ignored while in GRANT. gnt and sel never change during a grant.
- last without a transfer (out_ready=0 or req[sel]=0) has no effect.
- Single requester: after release it wins again on its next arbitration; this is legal.
- sel and gnt are registered (glitch-free for the mux select); out_valid and ack are combinational from registered state and inputs.

Optional Feature:
- Macro: ARB_BACK2BACK_EN.
- Defined:
  - On a release by last, the next owner is arbitrated in the same cycle from ptr_next=sel+1 using the current req with the old owner's bit masked.
  - If a winner exists, state stays GRANT and sel/gnt load the new owner at the edge, giving zero bubble.
  - If there is no winner, go to IDLE.
  - Watchdog revocation always goes to IDLE.
- Undefined: always a one-cycle IDLE bubble between grants, as described above.

Decomposition:
- Shared package mux4_arb_pkg:
  - state enum {ST_IDLE, ST_GRANT}
  - localparam NREQ=4
  - function onehot2 (2-bit to 4-bit one-hot)
- Sub-module rr_pick4: combinational; inputs req[3:0], ptr[1:0]; outputs found, win[1:0]. It is used once for IDLE arbitration and reused for the back-to-back path when ARB_BACK2BACK_EN is defined.
- The top level holds the FSM, ptr, watchdog counter and output logic.

Test Plan:
- Reset then req=4'b1010 -> next cycle gnt=4'b0010, sel=1; with out_ready=1, out_valid=1, ack=4'b0010.
- Owner 1 sends 3 beats with last on beat 3 while req=4'b1010 held -> ack[1] pulses 3 times; after the release, gnt=4'b1000, sel=3, ptr advanced (1 bubble cycle without the macro, 0 with it).
- Fairness: req=4'b1111 held, every grant single-beat (last=4'b1111) -> grant order 0,1,2,3,0; no requester waits more than 3 grants.
- Backpressure: owner 2 granted, out_ready=0 for 5 cycles with last[2]=1 -> ack=0, gnt held at 4'b0100; out_ready=1 -> ack[2]=1, then release.
- Watchdog: owner 0 granted, req[0] dropped for 15 cycles -> tmo pulses in the 15th stalled cycle, gnt=0 next, and a pending req[1] wins next arbitration.
- Reset mid-transfer: owner 3 on beat 2 of 4, rst=1 for one cycle -> gnt=0, sel=0, ptr=0; afterwards req=4'b1001 -> requester 0 granted.
